// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer with broadcast and drop accounting.
//
// A single producer presents a word with a lane select (or a broadcast flag);
// each output lane owns a one-entry holding register drained by its own
// consumer. Selects that name a non-existent lane are swallowed, flagged for
// one cycle and counted in a saturating counter.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    producer has a word
//   in_ready    word is accepted this cycle (combinational, independent of in_valid)
//   in_data     payload, DATA_W bits
//   in_sel      target lane, SEL_W bits
//   in_bcast    send to every lane, ignore in_sel
//   out_valid   per-lane word held, N_OUT bits
//   out_ready   per-lane consumer ready, N_OUT bits
//   out_data    lane k at [k*DATA_W +: DATA_W]
//   drop_pulse  one-cycle flag that an out-of-range word was dropped
//   drop_cnt    saturating count of dropped words, CNT_W bits
module demux_stream_1ton #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_OUT  = 8,
    parameter int unsigned SEL_W  = $clog2(N_OUT),
    parameter int unsigned CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    drop_pulse,
    output logic [CNT_W-1:0]        drop_cnt
);

    logic [N_OUT-1:0]             valid_q, valid_d;
    logic [N_OUT-1:0][DATA_W-1:0] data_q, data_d;
    logic                         drop_pulse_q, drop_pulse_d;
    logic [CNT_W-1:0]             drop_cnt_q, drop_cnt_d;

    logic [N_OUT-1:0] free;
    logic [N_OUT-1:0] sel_hit;
    logic [N_OUT-1:0] load;
    logic             sel_in_range;
    logic             accept;
    logic             drop;

    // A lane being drained this cycle can take a new word on the same edge.
    assign free = ~valid_q | out_ready;

    // One-hot decode of the select; all-zero when the select is out of range.
    always_comb begin
        sel_hit = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            sel_hit[k] = (32'(in_sel) == k);
        end
    end

    assign sel_in_range = (32'(in_sel) < N_OUT);

    // Out-of-range words are always drainable so the producer never deadlocks.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &free;
        end else if (sel_in_range) begin
            in_ready = |(sel_hit & free);
        end
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~in_bcast & ~sel_in_range;
    assign load   = accept ? (in_bcast ? {N_OUT{1'b1}} : sel_hit) : '0;

    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        drop_pulse_d = drop;
        drop_cnt_d   = drop_cnt_q;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            // Load takes priority over a simultaneous drain.
            if (load[k]) begin
                valid_d[k] = 1'b1;
                data_d[k]  = in_data;
            end else if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            data_q       <= '0;
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
